adder_rr_scheduler: RTL and testbench
=====================================

// Module: adder_rr_scheduler
// PURPOSE
//  Shares one 2-stage pipelined WIDTH-bit adder among NUM_REQ requesters.
//  Round-robin arbitration; one operation accepted per clock at most.
//  Results go into a small response FIFO, tagged with the requester ID, under
//  credit-based flow control. Sits between client engines and the adder datapath.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  WIDTH       16  operand width; the result is WIDTH+1 bits
//  FIFO_DEPTH  4   response FIFO entries (power of two, >=2)
//  ID_W        (localparam) $clog2(NUM_REQ)
// PORTS
//  clock      in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-high; clears all state
//  req_valid  in   NUM_REQ        request i is presenting operands
//  req_a      in   NUM_REQ*WIDTH  operand A; slice i = [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  operand B; same packing
//  req_ready  out  NUM_REQ        one-hot or zero; accept = req_valid[i]&req_ready[i]
//  rsp_valid  out  1              FIFO head is valid
//  rsp_id     out  ID_W           requester index of the head result
//  rsp_sum    out  WIDTH+1        {carry, sum} of the head result
//  rsp_ready  in   1              consumer pops the head when rsp_valid&rsp_ready
//  busy       out  1              s1_valid | FIFO not empty
// BEHAVIOUR
//  - Reset (async assert, sync deassert upstream): s1_valid=0, FIFO empty,
//    rr_ptr=NUM_REQ-1. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0,
//    busy=0. In-flight ops are discarded; reset mid-operation loses them silently.
//  - Credit: can_issue = (fifo_count + s1_valid) < FIFO_DEPTH.
//    A same-cycle pop is not credited, so behaviour is deterministic.
//  - Grant: search starts at index (rr_ptr+1) mod NUM_REQ and takes the first i
//    with req_valid[i]. req_ready[i] = can_issue & grant[i], combinational from
//    req_valid. Requesters must not make req_valid depend on req_ready.
//  - Requester side: once req_valid is asserted, it stays high with stable
//    operands until accepted.
//  - On accept at edge T: stage1 <= {a, b, id}, s1_valid <= 1, rr_ptr <= id.
//    rr_ptr does not change when nothing is accepted.
//  - Edge T+1: stage1 computes {carry, sum} = a + b, zero-extended to WIDTH+1.
//    The result and id are written to the FIFO and s1_valid clears, unless
//    another op is accepted at the same edge.
//  - Latency: accept edge T -> rsp_valid visible after edge T+1 if the FIFO was
//    empty. Peak throughput is 1 op/clock while rsp_ready=1.
//  - FIFO: first-word-registered head. rsp_* hold stable while rsp_valid & !rsp_ready.
//    Push and pop in the same cycle is legal; count is unchanged and order is kept.
//  - Full: FIFO holds (FIFO_DEPTH - s1_valid) entries -> req_ready all 0. The
//    FIFO is never written while full; overflow is impossible by construction.
//  - Empty: rsp_valid=0 and rsp_id/rsp_sum hold their last value.
//    A pop while empty is ignored.
//  - Width rule: no truncation; 0xFFFF+0x0001 gives rsp_sum=17'h1_0000.
//  - rr_ptr and FIFO pointers wrap modulo NUM_REQ and FIFO_DEPTH respectively.
// STRUCTURE
//  - Package adder_sched_pkg: DEF_WIDTH, DEF_NUM_REQ, DEF_FIFO_DEPTH;
//    typedef rsp_entry_t {id, carry, sum}.
//  - Sub-module rsp_fifo: sync FIFO parameterised by DEPTH and entry width, with
//    async-reset pointers and a count output.
//  - The adder is an inline a+b inside stage1; no separate adder instance.
// TESTING
//  1 Reset mid-stream: issue 3 ops, assert reset at a negedge
//    -> rsp_valid=0, busy=0 immediately; after release req0 wins first.
//  2 Single op: req1 a=16'h0003 b=16'h0004, rsp_ready=1 -> rsp_valid two edges
//    after accept; rsp_id=1, rsp_sum=17'h0_0007.
//  3 Carry: a=16'hFFFF b=16'h0001 -> rsp_sum=17'h1_0000;
//    a=b=16'hFFFF -> 17'h1_FFFE.
//  4 Fairness: all 4 req_valid held high, rsp_ready=1 for 8 clocks
//    -> grant order 0,1,2,3,0,1,2,3; one accept per clock.
//  5 Backpressure: rsp_ready=0, req0 continuously valid -> exactly 4 accepts, then
//    req_ready=0. Raising rsp_ready for 1 clock -> 1 pop, 1 new accept the next clock.
//  6 Order and ID: interleave req2/req0 with distinct operands under random
//    rsp_ready -> responses arrive in accept order with correct id and sum;
//    scoreboard finds no drops or duplicates.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared defaults and the response entry layout for the shared-adder scheduler.
package adder_sched_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   // Layout of one response entry in the default configuration (MSB first).
   typedef struct packed {
      logic [$clog2(DEF_NUM_REQ)-1:0] id;
      logic                           carry;
      logic [DEF_WIDTH-1:0]           sum;
   } rsp_entry_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO with a registered head word and an occupancy count.
// The head register always holds the oldest entry; when the FIFO drains it keeps
// the last value that was presented.
module rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
)(
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] rdata,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [DW-1:0] head_r;
   logic          valid_r;

   logic          push_s;
   logic          pop_s;
   logic [PW-1:0] rd_nxt_s;
   logic [CW-1:0] count_nxt_s;
   logic [DW-1:0] head_nxt_s;

   // Qualify push/pop (no pop when empty, no write when full) and derive next pointers/count.
   always_comb begin
      pop_s       = pop && (count_r != {CW{1'b0}});
      push_s      = push && (count_r != CW'(DEPTH));
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      if (pop_s) begin
         rd_nxt_s = rd_ptr_r + PW'(1);
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
   end

   // Next head word: the entry at the new read pointer, bypassing a write landing there.
   always_comb begin
      head_nxt_s = head_r;
      if (count_nxt_s != {CW{1'b0}}) begin
         if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = wdata;
         end else begin
            head_nxt_s = mem_r[rd_nxt_s];
         end
      end else begin
         head_nxt_s = head_r;
      end
   end

   // Storage, pointers, count and registered head.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         head_r   <= {DW{1'b0}};
         valid_r  <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         rd_ptr_r <= rd_nxt_s;
         count_r  <= count_nxt_s;
         head_r   <= head_nxt_s;
         valid_r  <= (count_nxt_s != {CW{1'b0}});
      end
   end

   assign valid = valid_r;
   assign rdata = head_r;
   assign count = count_r;

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one two-stage adder among NUM_REQ requesters.
// Results are tagged with the requester index and queued in a response FIFO;
// issue is gated by credit so the FIFO can never overflow.
module adder_rr_scheduler
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int ID_W      = $clog2(NUM_REQ)
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH:0]           rsp_sum,
   input  logic                     rsp_ready,
   output logic                     busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = ID_W + WIDTH + 1;

   logic [ID_W-1:0]    rr_ptr_r;
   logic               s1_valid_r;
   logic [WIDTH-1:0]   s1_a_r;
   logic [WIDTH-1:0]   s1_b_r;
   logic [ID_W-1:0]    s1_id_r;

   logic [NUM_REQ-1:0] grant_s;
   logic [ID_W-1:0]    grant_id_s;
   logic               found_s;
   int                 scan_idx_s;
   logic               can_issue_s;
   logic               accept_s;
   logic [WIDTH-1:0]   sel_a_s;
   logic [WIDTH-1:0]   sel_b_s;
   logic [WIDTH:0]     sum_s;
   logic [ENT_W-1:0]   push_entry_s;
   logic [CNT_W-1:0]   fifo_count_s;
   logic               fifo_valid_s;
   logic [ENT_W-1:0]   fifo_rdata_s;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant_s    = {NUM_REQ{1'b0}};
      grant_id_s = {ID_W{1'b0}};
      found_s    = 1'b0;
      scan_idx_s = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
         if (!found_s && req_valid[scan_idx_s]) begin
            found_s             = 1'b1;
            grant_s[scan_idx_s] = 1'b1;
            grant_id_s          = ID_W'(scan_idx_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Credit: entries already queued plus the one in flight; a same-cycle pop is not counted.
   assign can_issue_s = ({1'b0, fifo_count_s} + (CNT_W+1)'(s1_valid_r)) < (CNT_W+1)'(FIFO_DEPTH);
   assign req_ready   = (can_issue_s && !reset) ? grant_s : {NUM_REQ{1'b0}};
   assign accept_s    = |(req_valid & req_ready);
   assign sel_a_s     = req_a[int'(grant_id_s)*WIDTH +: WIDTH];
   assign sel_b_s     = req_b[int'(grant_id_s)*WIDTH +: WIDTH];

   // Stage 1 capture of the granted operands and round-robin pointer update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {WIDTH{1'b0}};
         s1_b_r     <= {WIDTH{1'b0}};
         s1_id_r    <= {ID_W{1'b0}};
         rr_ptr_r   <= ID_W'(NUM_REQ - 1);
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_a_r     <= sel_a_s;
         s1_b_r     <= sel_b_s;
         s1_id_r    <= grant_id_s;
         rr_ptr_r   <= grant_id_s;
      end else begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: full-width add, carry kept as the MSB, tagged with the requester index.
   assign sum_s        = {1'b0, s1_a_r} + {1'b0, s1_b_r};
   assign push_entry_s = {s1_id_r, sum_s};

   rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (ENT_W)
   ) u_rsp_fifo (
      .clock (clock),
      .reset (reset),
      .push  (s1_valid_r),
      .wdata (push_entry_s),
      .pop   (rsp_ready),
      .valid (fifo_valid_s),
      .rdata (fifo_rdata_s),
      .count (fifo_count_s)
   );

   assign rsp_valid = fifo_valid_s;
   assign rsp_id    = fifo_rdata_s[ENT_W-1 -: ID_W];
   assign rsp_sum   = fifo_rdata_s[WIDTH:0];
   assign busy      = s1_valid_r | fifo_valid_s;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed self-checking bench for adder_rr_scheduler (4 requesters, 16-bit, depth 4).
module tb_adder_rr_scheduler;

   localparam int NR = 4;
   localparam int W  = 16;
   localparam int IW = 2;

   logic            clock;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR*W-1:0] req_a;
   logic [NR*W-1:0] req_b;
   logic [NR-1:0]   req_ready;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [W:0]      rsp_sum;
   logic            rsp_ready;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   adder_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .FIFO_DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      req_valid = '0;
      rsp_ready = 1'b0;
      reset     = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      req_valid = 4'b0111;
      rsp_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         req_a[i*W +: W] = 16'(i + 1);
         req_b[i*W +: W] = 16'h0010;
      end
      step(); step(); step();
      #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
      reset = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b busy=%b ready=%b exp 0/0/0000", rsp_valid, busy, req_ready);
      end
      checks++;
      if (rsp_id !== 2'd0 || rsp_sum !== 17'h0_0000) begin
         failures++;
         $display("FAIL reset_data got id=%0d sum=%h exp 0/0", rsp_id, rsp_sum);
      end
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_single_op();
      do_reset();
      req_valid = 4'b0010;
      req_a[1*W +: W] = 16'h0003;
      req_b[1*W +: W] = 16'h0004;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL single_stage1 got valid=%b busy=%b exp 0/1", rsp_valid, busy);
      end
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 17'h0_0007) begin
         failures++; $display("FAIL single_rsp got v=%b id=%0d sum=%h exp 1/1/00007", rsp_valid, rsp_id, rsp_sum);
      end
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== 17'h0_0007) begin
         failures++; $display("FAIL single_drain got v=%b busy=%b sum=%h exp 0/0/00007", rsp_valid, busy, rsp_sum);
      end
   endtask

   task automatic test_carry();
      logic [W-1:0] va [2];
      logic [W-1:0] vb [2];
      logic [W:0]   ve [2];
      int           vr [2];
      va[0] = 16'hFFFF; vb[0] = 16'h0001; ve[0] = 17'h1_0000; vr[0] = 3;
      va[1] = 16'hFFFF; vb[1] = 16'hFFFF; ve[1] = 17'h1_FFFE; vr[1] = 0;
      do_reset();
      rsp_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         req_valid = '0;
         req_valid[vr[v]] = 1'b1;
         req_a[vr[v]*W +: W] = va[v];
         req_b[vr[v]*W +: W] = vb[v];
         step();
         req_valid = '0;
         step();
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_sum !== ve[v] || rsp_id !== IW'(vr[v])) begin
            failures++;
            $display("FAIL carry_%0d got v=%b id=%0d sum=%h exp 1/%0d/%h", v, rsp_valid, rsp_id, rsp_sum, vr[v], ve[v]);
         end
         step();
      end
   endtask

   task automatic test_fairness();
      logic [NR-1:0] exp_ready;
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) begin
         req_a[i*W +: W] = 16'(16'h0100 * (i + 1));
         req_b[i*W +: W] = 16'(i);
      end
      for (int c = 0; c < 8; c++) begin
         #1;
         exp_ready = 4'b0001 << (c % 4);
         checks++;
         if (req_ready !== exp_ready) begin
            failures++; $display("FAIL fair_grant_%0d got=%b exp=%b", c, req_ready, exp_ready);
         end
         if (c >= 2) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IW'((c - 2) % 4)) begin
               failures++; $display("FAIL fair_rsp_%0d got v=%b id=%0d exp 1/%0d", c, rsp_valid, rsp_id, (c - 2) % 4);
            end
         end
         step();
      end
      req_valid = '0;
      step(); step(); step();
   endtask

   task automatic test_backpressure();
      int accepts;
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      req_b[0 +: W] = 16'h0010;
      accepts = 0;
      for (int c = 0; c < 8; c++) begin
         req_a[0 +: W] = 16'(accepts + 1);
         #1;
         if (req_ready[0]) accepts++;
         step();
      end
      #1;
      checks++;
      if (accepts !== 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", accepts); end
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 17'h0_0011) begin
         failures++; $display("FAIL bp_full got ready=%b v=%b sum=%h exp 0000/1/00011", req_ready, rsp_valid, rsp_sum);
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_pop_not_credited got=%b exp=0000", req_ready); end
      step();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001 || rsp_sum !== 17'h0_0012) begin
         failures++; $display("FAIL bp_after_pop got ready=%b sum=%h exp 0001/00012", req_ready, rsp_sum);
      end
      step();
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_refull got=%b exp=0000", req_ready); end
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) step();
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         failures++; $display("FAIL bp_drain got busy=%b v=%b exp 0/0", busy, rsp_valid);
      end
   endtask

   task automatic test_order_id();
      logic [IW+W:0] sb [$];
      logic [IW+W:0] exp_e;
      logic [W-1:0]  oa;
      logic [W-1:0]  ob;
      int            idx [2];
      int            rid [2];
      int            popped;
      int            cyc;
      idx[0] = 0; idx[1] = 0;
      rid[0] = 0; rid[1] = 2;
      popped = 0;
      cyc    = 0;
      do_reset();
      while ((idx[0] < 4 || idx[1] < 4 || popped < 8) && cyc < 300) begin
         rsp_ready = 1'($urandom_range(0, 1));
         req_valid = '0;
         for (int r = 0; r < 2; r++) begin
            if (idx[r] < 4) begin
               if (r == 0) begin
                  oa = 16'(16'hF000 + idx[r] * 16'h0321);
                  ob = 16'(16'h1234 * (idx[r] + 1));
               end else begin
                  oa = 16'(16'h0101 * (idx[r] + 3));
                  ob = 16'(16'hFFFF - idx[r]);
               end
               req_valid[rid[r]] = 1'b1;
               req_a[rid[r]*W +: W] = oa;
               req_b[rid[r]*W +: W] = ob;
            end
         end
         #1;
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++; $display("FAIL order_dup got id=%0d sum=%h exp none", rsp_id, rsp_sum);
            end else begin
               exp_e = sb.pop_front();
               if ({rsp_id, rsp_sum} !== exp_e) begin
                  failures++;
                  $display("FAIL order_rsp_%0d got id=%0d sum=%h exp id=%0d sum=%h",
                           popped, rsp_id, rsp_sum, exp_e[IW+W:W+1], exp_e[W:0]);
               end
            end
            popped++;
         end
         for (int r = 0; r < 2; r++) begin
            if (req_valid[rid[r]] && req_ready[rid[r]]) begin
               oa = req_a[rid[r]*W +: W];
               ob = req_b[rid[r]*W +: W];
               sb.push_back({IW'(rid[r]), {1'b0, oa} + {1'b0, ob}});
               idx[r]++;
            end
         end
         step();
         cyc++;
      end
      req_valid = '0;
      checks++;
      if (popped !== 8 || sb.size() !== 0 || idx[0] !== 4 || idx[1] !== 4) begin
         failures++;
         $display("FAIL order_totals got popped=%0d left=%0d acc0=%0d acc2=%0d exp 8/0/4/4",
                  popped, sb.size(), idx[0], idx[1]);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      step();
      reset = 1'b0;
      test_reset();
      test_single_op();
      test_carry();
      test_fairness();
      test_backpressure();
      test_order_id();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
